// File: rtl/pixel_coord_gen.sv
// Walks a raster of H_RES x V_RES pixels, handing each pixel's complex coordinate to the
// depth engine and waiting for its result before moving on.
module pixel_coord_gen #(
    parameter int unsigned WORD_LENGTH = 32,
    parameter int unsigned FRAC        = 28,
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480
) (
    input  logic                          sysclk,
    input  logic                          reset,
    input  logic                          frame_start,
    input  logic                          abort,
    input  logic signed [WORD_LENGTH-1:0] re_origin,
    input  logic signed [WORD_LENGTH-1:0] im_origin,
    input  logic signed [WORD_LENGTH-1:0] step,
    input  logic                          engine_written,
    output logic signed [WORD_LENGTH-1:0] re_c,
    output logic signed [WORD_LENGTH-1:0] im_c,
    output logic                          start,
    output logic [9:0]                    x,
    output logic [9:0]                    y,
    output logic                          busy,
    output logic                          frame_done
);

    if (FRAC >= WORD_LENGTH) begin : g_bad_frac
        $error("FRAC must be smaller than WORD_LENGTH");
    end

    localparam logic [9:0] XLast = 10'(H_RES - 1);
    localparam logic [9:0] YLast = 10'(V_RES - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StIssue, StWait, StAdvance} state_e;

    state_e                        state_q;
    logic signed [WORD_LENGTH-1:0] re_org_q, step_q, re_q, im_q;
    logic [9:0]                    x_q, y_q;
    logic                          start_q, busy_q, done_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q  <= StIdle;
            re_org_q <= '0;
            step_q   <= '0;
            re_q     <= '0;
            im_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            // abort wins over every other input in every state; coordinates just stay put
            if (abort) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (frame_start) begin
                            state_q <= StLoad;
                            busy_q  <= 1'b1;
                        end
                    end
                    StLoad: begin
                        re_org_q <= re_origin;
                        step_q   <= step;
                        re_q     <= re_origin;
                        im_q     <= im_origin;
                        x_q      <= '0;
                        y_q      <= '0;
                        start_q  <= 1'b1;
                        state_q  <= StIssue;
                    end
                    StIssue: begin
                        state_q <= StWait;
                    end
                    StWait: begin
                        if (engine_written) begin
                            state_q <= StAdvance;
                        end
                    end
                    StAdvance: begin
                        if (x_q != XLast) begin
                            x_q     <= x_q + 10'd1;
                            re_q    <= re_q + step_q;
                            start_q <= 1'b1;
                            state_q <= StIssue;
                        end else if (y_q != YLast) begin
                            x_q     <= '0;
                            re_q    <= re_org_q;
                            y_q     <= y_q + 10'd1;
                            im_q    <= im_q - step_q;
                            start_q <= 1'b1;
                            state_q <= StIssue;
                        end else begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign re_c       = re_q;
    assign im_c       = im_q;
    assign x          = x_q;
    assign y          = y_q;
    assign start      = start_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule
